// File: rtl/message_scroll_ctrl.sv
// message_scroll_ctrl
//   Scrolls one of four fixed ROM messages through an 8-character display
//   window, one character per clock, then pads with 8 spaces so the text
//   scrolls fully off before signalling completion.
//
// Ports
//   sec_clock   : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset
//   req[3:0]    : level requests, bit i requests message i
//   abort       : cancels the message in progress (ignored when idle)
//   grant[3:0]  : one-hot message being scrolled, 0 when idle
//   busy        : high while shifting characters or padding
//   done        : one-cycle pulse on normal completion
//   instruction : 8 five-bit char codes, newest in [4:0], oldest in [39:35]
//   hold        : freezes scrolling (only with SCROLL_HOLD_EN defined)
//
// Build option: define SCROLL_HOLD_EN to add the hold input.
module message_scroll_ctrl (
    input  logic        sec_clock,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        abort,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        done,
    output logic [39:0] instruction
`ifdef SCROLL_HOLD_EN
    ,
    input  logic        hold
`endif
);

    typedef enum logic [1:0] {StIdle, StShift, StPad} state_e;

    state_e      state_q, state_d;
    logic [39:0] instr_q, instr_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  msg_q, msg_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  pad_q, pad_d;
    logic        done_q, done_d;

    logic        frozen;
    logic [1:0]  winner;
    logic [1:0]  cand;
    logic [4:0]  cur_char;

`ifdef SCROLL_HOLD_EN
    assign frozen = hold;
`else
    assign frozen = 1'b0;
`endif

    // Messages are stored as space-padded ASCII; first character in the MSBs.
    // Letters map to their alphabet position, space maps to 0.
    function automatic logic [4:0] rom_char(input logic [1:0] m, input logic [3:0] i);
        logic [127:0] s;
        logic [7:0]   c;
        logic [7:0]   t;
        unique case (m)
            2'd0:    s = "WELCOME         ";
            2'd1:    s = "CONVERT CURRENCY";
            2'd2:    s = "WITHDRAW        ";
            default: s = "ERROR           ";
        endcase
        c = s[8*(15-i) +: 8];
        t = c - 8'h40;
        return (c == 8'h20) ? 5'd0 : t[4:0];
    endfunction

    function automatic logic [3:0] msg_last(input logic [1:0] m);
        unique case (m)
            2'd0:    return 4'd6;
            2'd1:    return 4'd15;
            2'd2:    return 4'd7;
            default: return 4'd4;
        endcase
    endfunction

    // Round-robin: scan offsets high to low so the nearest requester at or
    // above ptr is the last one written.
    always_comb begin
        winner = ptr_q;
        cand   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) winner = cand;
        end
    end

    assign cur_char = rom_char(msg_q, idx_q);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        grant_d = grant_q;
        msg_d   = msg_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        pad_d   = pad_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    grant_d = 4'b0001 << winner;
                    msg_d   = winner;
                    ptr_d   = winner + 2'd1;
                    instr_d = '0;
                    idx_d   = '0;
                    state_d = StShift;
                end
            end
            StShift, StPad: begin
                if (abort) begin
                    instr_d = '0;
                    grant_d = '0;
                    state_d = StIdle;
                end else if (!frozen) begin
                    if (state_q == StShift) begin
                        instr_d = {instr_q[34:0], cur_char};
                        idx_d   = idx_q + 4'd1;
                        if (idx_q == msg_last(msg_q)) begin
                            pad_d   = '0;
                            state_d = StPad;
                        end
                    end else begin
                        instr_d = {instr_q[34:0], 5'b00000};
                        pad_d   = pad_q + 3'd1;
                        if (pad_q == 3'd7) begin
                            grant_d = '0;
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sec_clock) begin
        if (rst) begin
            state_q <= StIdle;
            instr_q <= '0;
            grant_q <= '0;
            msg_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            pad_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            grant_q <= grant_d;
            msg_q   <= msg_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            pad_q   <= pad_d;
            done_q  <= done_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign instruction = instr_q;

endmodule

// File: tb/tb_message_scroll_ctrl.sv
module tb_message_scroll_ctrl;

    logic        sec_clock = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic        abort = 1'b0;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic [39:0] instruction;
`ifdef SCROLL_HOLD_EN
    logic        hold = 1'b0;
`endif

    int pass_cnt = 0;
    int check_cnt = 0;

    message_scroll_ctrl dut (
        .sec_clock  (sec_clock),
        .rst        (rst),
        .req        (req),
        .abort      (abort),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .instruction(instruction)
`ifdef SCROLL_HOLD_EN
        ,
        .hold       (hold)
`endif
    );

    always #5 sec_clock = ~sec_clock;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge sec_clock);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b0000;
        abort = 1'b0;
        do_reset();
        check_cnt++;
        if (instruction !== 40'd0) $display("FAIL reset_instr: got %h want 0", instruction);
        else pass_cnt++;
        check_cnt++;
        if ({grant, busy, done} !== 6'b0) $display("FAIL reset_ctl: got %b want 000000", {grant, busy, done});
        else pass_cnt++;
    endtask

    task automatic test_currency();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        check_cnt++;
        if ({grant, busy} !== 5'b0010_1) $display("FAIL cur_grant: got %b want 00101", {grant, busy});
        else pass_cnt++;
        repeat (16) tick();
        check_cnt++;
        if (instruction !== 40'b00011_10101_10010_10010_00101_01110_00011_11001)
            $display("FAIL cur_window: got %b want CURRENCY codes", instruction);
        else pass_cnt++;
        repeat (7) tick();
        check_cnt++;
        if ({done, busy} !== 2'b01) $display("FAIL cur_predone: got %b want 01", {done, busy});
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({done, busy, grant} !== 6'b1_0_0000) $display("FAIL cur_done: got %b want 100000", {done, busy, grant});
        else pass_cnt++;
        check_cnt++;
        if (instruction !== 40'd0) $display("FAIL cur_done_instr: got %h want 0", instruction);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (done !== 1'b0) $display("FAIL cur_done_pulse: got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lens [4] = '{7, 16, 8, 5};
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        tick();
        check_cnt++;
        if (grant !== 4'b0001) $display("FAIL rr_first: got %b want 0001", grant);
        else pass_cnt++;
        for (int n = 0; n < 4; n++) begin
            exp_g = 4'b0001 << ((n + 1) % 4);
            repeat (lens[n] + 7) tick();
            check_cnt++;
            if (done !== 1'b0) $display("FAIL rr_early_done%0d: got %b want 0", n, done);
            else pass_cnt++;
            tick();
            check_cnt++;
            if (done !== 1'b1) $display("FAIL rr_done%0d: got %b want 1", n, done);
            else pass_cnt++;
            tick();
            check_cnt++;
            if ({grant, busy} !== {exp_g, 1'b1}) $display("FAIL rr_grant%0d: got %b want %b1", n, {grant, busy}, exp_g);
            else pass_cnt++;
        end
        req = 4'b0000;
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        check_cnt++;
        if (grant !== 4'b1000) $display("FAIL ab_grant: got %b want 1000", grant);
        else pass_cnt++;
        repeat (3) tick();
        check_cnt++;
        if (instruction !== 40'b00101_10010_10010) $display("FAIL ab_err: got %b want ERR codes", instruction);
        else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_cnt++;
        if ({instruction, grant, busy, done} !== 46'd0) $display("FAIL ab_clear: got %h/%b/%b/%b want all 0", instruction, grant, busy, done);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (done !== 1'b0) $display("FAIL ab_nodone: got %b want 0", done);
        else pass_cnt++;
        // ptr wrapped to 0 after msg3; abort in idle must not block this grant
        req = 4'b1111;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        req = 4'b0000;
        check_cnt++;
        if ({grant, busy} !== 5'b0001_1) $display("FAIL ab_ptr0: got %b want 00011", {grant, busy});
        else pass_cnt++;
        // abort on the completing edge of msg3 wins over done
        do_reset();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        repeat (12) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_cnt++;
        if ({done, busy, grant} !== 6'b0) $display("FAIL ab_last: got %b want 000000", {done, busy, grant});
        else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        repeat (4) tick();
        check_cnt++;
        if (instruction[19:0] !== 20'b10111_00101_01100_00011) $display("FAIL rm_welc: got %b want WELC codes", instruction[19:0]);
        else pass_cnt++;
        rst = 1'b1;
        abort = 1'b1;
        tick();
        rst = 1'b0;
        abort = 1'b0;
        check_cnt++;
        if ({instruction, grant, busy, done} !== 46'd0) $display("FAIL rm_reset: got %h/%b/%b/%b want all 0", instruction, grant, busy, done);
        else pass_cnt++;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        check_cnt++;
        if ({grant, busy} !== 5'b0100_1) $display("FAIL rm_grant2: got %b want 01001", {grant, busy});
        else pass_cnt++;
        tick();
        tick();
        check_cnt++;
        if (instruction !== 40'b10111_01001) $display("FAIL rm_wi: got %b want WI codes", instruction);
        else pass_cnt++;
    endtask

`ifdef SCROLL_HOLD_EN
    task automatic test_hold();
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        repeat (4) tick();
        hold = 1'b1;
        repeat (10) tick();
        hold = 1'b0;
        check_cnt++;
        if (instruction !== 40'b10111_01001_10100_01000) $display("FAIL hold_with: got %b want WITH codes", instruction);
        else pass_cnt++;
        repeat (11) tick();
        check_cnt++;
        if (done !== 1'b0) $display("FAIL hold_early: got %b want 0", done);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (done !== 1'b1) $display("FAIL hold_done: got %b want 1", done);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_currency();
        test_back_to_back();
        test_abort();
        test_rst_mid();
`ifdef SCROLL_HOLD_EN
        test_hold();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/message_scroll_ctrl.md
MESSAGE_SCROLL_CTRL -- requirements
Module: message_scroll_ctrl

Interface
REQ-001 SHALL have port sec_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port req, input, 4 bits: level message requests; bit i requests message i.
REQ-004 SHALL have port abort, input, 1 bit: cancels the message in progress.
REQ-005 SHALL have port grant, output, 4 bits: one-hot; identifies the message being scrolled, 0 when idle.
REQ-006 SHALL have port busy, output, 1 bit: high while in SHIFT or PAD.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse on normal message completion.
REQ-008 SHALL have port instruction, output, 40 bits: display window of 8 five-bit character codes; newest character in [4:0], oldest in [39:35].
REQ-009 SHALL have port hold, input, 1 bit, present only when SCROLL_HOLD_EN is defined: freezes scrolling.

Function
REQ-010 Character code SHALL be: space = 5'b00000, letters A..Z = 5'b00001..5'b11010.
REQ-011 Internal ROM SHALL hold 4 messages: msg0 "WELCOME" (len 7), msg1 "CONVERT CURRENCY" (len 16), msg2 "WITHDRAW" (len 8), msg3 "ERROR" (len 5).
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and PAD; the encoding is free.
REQ-013 In IDLE with req != 0, the block SHALL perform the following at the next edge: grant the winner by round-robin, clear instruction to 0, set char index to 0, set busy = 1, and enter SHIFT.
REQ-014 Round-robin SHALL start the search at pointer ptr and proceed upward modulo 4; ptr resets to 0.
REQ-015 On each grant, ptr SHALL be set to (granted index + 1) mod 4, whether the message later completes or aborts.
REQ-016 In IDLE with req == 0, all outputs SHALL hold.
REQ-017 In SHIFT, each edge SHALL perform instruction <= {instruction[34:0], ROM[msg][idx]} and idx <= idx + 1.
REQ-018 The edge that shifts the last character (idx == len-1) SHALL enter PAD with the pad counter at 0.
REQ-019 In PAD, each edge SHALL shift in 5'b00000 and increment the 3-bit pad counter.
REQ-020 The 8th pad shift SHALL complete the message: state to IDLE, grant = 0, busy = 0, done = 1 for exactly that one cycle.
REQ-021 Latency: with a grant at edge k, character j (1-based) SHALL enter [4:0] at edge k+j; done SHALL be high after edge k+len+8; the window SHALL be all zeros at that point.
REQ-022 Changes in req while busy SHALL be ignored; a requester SHALL keep req high until it sees its grant bit.
REQ-023 A request still asserted in the done cycle SHALL be eligible at the next edge; there are no dead cycles beyond the done cycle.
REQ-024 abort = 1 at an edge in SHIFT or PAD SHALL clear instruction to 0, set grant = 0 and busy = 0, and enter IDLE, with no done pulse.
REQ-025 abort in IDLE SHALL be ignored.
REQ-026 abort and a completing edge at the same time SHALL resolve as abort (no done).

Reset
REQ-027 rst = 1 at an edge SHALL force IDLE, instruction = 40'b0, grant = 0, busy = 0, done = 0, ptr = 0, idx = 0 and pad counter = 0.
REQ-028 rst SHALL override abort, hold and req, including mid-message.

Configuration
REQ-029 With SCROLL_HOLD_EN defined, hold = 1 in SHIFT or PAD SHALL freeze instruction, idx, pad counter and state; abort and rst SHALL still take effect while frozen.
REQ-030 Without SCROLL_HOLD_EN, the hold port SHALL be absent and scrolling SHALL never stall.

Verification
REQ-031 rst, then req = 4'b0010 held for 1 cycle -> grant = 4'b0010; after 16 shift edges the window reads C,U,R,R,E,N,C,Y (00011,10101,10010,10010,00101,01110,00011,11001); done pulses 8 edges later with instruction = 0.
REQ-032 req = 4'b1111 continuously from reset -> grants SHALL occur in order 0,1,2,3,0, with each done to the next grant exactly 1 edge apart.
REQ-033 msg3 granted, abort = 1 after 3 shifts (window E,R,R in the low 15 bits) -> next edge instruction = 0, grant = 0, busy = 0, no done; ptr = 0 afterwards.
REQ-034 msg0 running, rst = 1 on the 5th SHIFT edge with abort = 1 -> all outputs reset; a following req = 4'b0100 is granted msg2.
REQ-035 With SCROLL_HOLD_EN: msg2, hold = 1 for 10 cycles after 4 shifts -> window stays W,I,T,H; completion is delayed by exactly 10 cycles.
